// File: rtl/fod_hop_sequencer.sv
// fod_hop_sequencer: sequences FOD frequency hops and phase resync.
// Captures a requested FCW, optionally aligns the hop to a SYS_REF rising
// edge, then freezes calibration, loads the FCW, pulses the DSM/NCO sync
// resets and lets the loops settle before releasing calibration.
// Optional feature: define HOP_TIMEOUT_EN to bound the wait for SYS_REF;
// on expiry the hop is dropped and o_hop_err is set.
module fod_hop_sequencer #(
  parameter int                FCW_W       = 22,
  parameter logic [FCW_W-1:0]  FCW_INIT    = 22'h200000,
  parameter int                FREEZE_CYC  = 4,
  parameter int                SYNC_CYC    = 2,
  parameter int                SETTLE_CYC  = 16,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sys_en,
  input  logic             i_sys_ref,
  input  logic             i_hop_req,
  input  logic [FCW_W-1:0] i_hop_fcw,
  output logic             o_hop_ack,
  output logic [FCW_W-1:0] o_fcw_fod,
  output logic             o_dsm_sync_nrst,
  output logic             o_nco_sync_nrst,
  output logic             o_cali_freeze,
  output logic             o_busy,
  output logic             o_hop_done,
  output logic             o_hop_err
);

  // Counter is shared by every timed state, so size it for the longest one.
  localparam int MAX_SEQ = (FREEZE_CYC > SYNC_CYC)
                         ? ((FREEZE_CYC > SETTLE_CYC) ? FREEZE_CYC : SETTLE_CYC)
                         : ((SYNC_CYC > SETTLE_CYC) ? SYNC_CYC : SETTLE_CYC);
`ifdef HOP_TIMEOUT_EN
  localparam int MAX_CNT = (MAX_SEQ > TIMEOUT_CYC) ? MAX_SEQ : TIMEOUT_CYC;
`else
  localparam int MAX_CNT = MAX_SEQ;
`endif
  localparam int CNT_W = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] FREEZE_LD = CNT_W'(FREEZE_CYC - 1);
  localparam logic [CNT_W-1:0] SYNC_LD   = CNT_W'(SYNC_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef HOP_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYC - 1);
`endif

  // S_DONE is a one-cycle tail so that o_hop_done lines up with the cycle
  // calibration is released, and a held request is only taken afterwards.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_FREEZE = 3'd2,
    S_LOAD   = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_capture;
`ifdef HOP_TIMEOUT_EN
  logic               w_timeout;
  logic               r_hop_err;
`endif

  logic               r_ref_s1;
  logic               r_ref_s2;
  logic               r_ref_s3;
  logic               w_ref_rise;

  logic [FCW_W-1:0]   r_fcw_nxt;
  logic [FCW_W-1:0]   r_fcw_fod;
  logic               r_hop_ack;
  logic               r_sync_nrst;
  logic               r_cali_freeze;
  logic               r_busy;
  logic               r_hop_done;

  // SYS_REF synchronizer plus one extra stage for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ref_s1 <= 1'b0;
      r_ref_s2 <= 1'b0;
      r_ref_s3 <= 1'b0;
    end else begin
      r_ref_s1 <= i_sys_ref;
      r_ref_s2 <= r_ref_s1;
      r_ref_s3 <= r_ref_s2;
    end
  end

  assign w_ref_rise = r_ref_s2 & ~r_ref_s3;

  // State and step counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter decode; each timed state counts down to zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
`ifdef HOP_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_hop_req) begin
          w_capture = 1'b1;
          if (i_sys_en) begin
            w_state_next = S_ARM;
`ifdef HOP_TIMEOUT_EN
            w_cnt_next   = TMO_LD;
`endif
          end else begin
            w_state_next = S_FREEZE;
            w_cnt_next   = FREEZE_LD;
          end
        end
      end
      S_ARM: begin
        if (w_ref_rise || !i_sys_en) begin
          w_state_next = S_FREEZE;
          w_cnt_next   = FREEZE_LD;
        end
`ifdef HOP_TIMEOUT_EN
        else if (r_cnt == '0) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
`endif
      end
      S_FREEZE: begin
        if (r_cnt == '0) begin
          w_state_next = S_LOAD;
          w_cnt_next   = SYNC_LD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_LOAD: begin
        if (r_cnt == '0) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = SETTLE_LD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Registered outputs, decoded from the current state one cycle late so the
  // FCW update and sync-reset pulse land inside the calibration freeze window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fcw_nxt     <= FCW_INIT;
      r_fcw_fod     <= FCW_INIT;
      r_hop_ack     <= 1'b0;
      r_sync_nrst   <= 1'b1;
      r_cali_freeze <= 1'b0;
      r_busy        <= 1'b0;
      r_hop_done    <= 1'b0;
    end else begin
      r_hop_ack <= w_capture;
      if (w_capture) begin
        r_fcw_nxt <= i_hop_fcw;
      end
      if (r_state == S_LOAD) begin
        r_fcw_fod <= r_fcw_nxt;
      end
      r_sync_nrst   <= (r_state != S_LOAD);
      r_cali_freeze <= (r_state == S_FREEZE) || (r_state == S_LOAD) ||
                       (r_state == S_SETTLE);
      r_busy        <= (w_state_next != S_IDLE);
      r_hop_done    <= (r_state == S_DONE);
    end
  end

`ifdef HOP_TIMEOUT_EN
  // Sticky timeout flag, cleared when the next request is acknowledged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hop_err <= 1'b0;
    end else if (w_timeout) begin
      r_hop_err <= 1'b1;
    end else if (w_capture) begin
      r_hop_err <= 1'b0;
    end
  end

  assign o_hop_err = r_hop_err;
`else
  assign o_hop_err = 1'b0;
`endif

  assign o_hop_ack       = r_hop_ack;
  assign o_fcw_fod       = r_fcw_fod;
  assign o_dsm_sync_nrst = r_sync_nrst;
  assign o_nco_sync_nrst = r_sync_nrst;
  assign o_cali_freeze   = r_cali_freeze;
  assign o_busy          = r_busy;
  assign o_hop_done      = r_hop_done;

endmodule
